vend_sequencer: RTL and testbench

- Clocked controller that sequences the vending datapath (coin intake, can ejector, dime and nickel change ejectors).
- Accumulates credit from single-cycle coin events and issues a can dispense once credit reaches PRICE.
- Pays change greedily (dimes first, then nickels) against on-board inventory counters.
- Sits between the debounced coin/button front end and the ejector drivers; every ejector is driven through a REQ/ACK handshake.

---
 rtl/vend_sequencer.sv | 142 ++++++++++++++
 tb/tb_vend_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending controller: credit accumulation, can vend, greedy dime/nickel change
module vend_sequencer #(
    parameter int PRICE       = 30,
    parameter int CREDIT_W    = 7,
    parameter int INV_W       = 4,
    parameter int DIME_INIT   = 8,
    parameter int NICKEL_INIT = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                COIN_VALID,
    input  logic [1:0]          COIN_CODE,
    output logic                COIN_READY,
    output logic                COIN_REJECT,
    input  logic                CANCEL,
    input  logic                REFILL,
    output logic                CAN_REQ,
    input  logic                CAN_ACK,
    output logic                DIME_REQ,
    input  logic                DIME_ACK,
    output logic                NICKEL_REQ,
    input  logic                NICKEL_ACK,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic [INV_W-1:0]    DIME_CNT,
    output logic [INV_W-1:0]    NICKEL_CNT,
    output logic                BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_VEND, S_DIME, S_NICKEL} state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] DIME_V   = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] NICKEL_V = CREDIT_W'(5);

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n, coin_value;
    logic [INV_W-1:0]    dime_n, nickel_n;
    logic                can_req_n, dime_req_n, nickel_req_n, reject_n;
    logic                accept, ack_now;

    // Greedy change selection; a remainder that cannot be paid falls back to IDLE as carry-over.
    function automatic state_t change_path(input logic [CREDIT_W-1:0] rem,
                                           input logic [INV_W-1:0] d,
                                           input logic [INV_W-1:0] n);
        if (rem >= DIME_V && d != '0)
            return S_DIME;
        else if (rem >= NICKEL_V && n != '0)
            return S_NICKEL;
        else
            return S_IDLE;
    endfunction

    assign accept = COIN_VALID && COIN_READY;

    always_comb begin
        case (COIN_CODE)
            2'b00:   coin_value = NICKEL_V;
            2'b01:   coin_value = DIME_V;
            2'b10:   coin_value = CREDIT_W'(25);
            default: coin_value = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            CREDIT      <= '0;
            DIME_CNT    <= INV_W'(DIME_INIT);
            NICKEL_CNT  <= INV_W'(NICKEL_INIT);
            CAN_REQ     <= 1'b0;
            DIME_REQ    <= 1'b0;
            NICKEL_REQ  <= 1'b0;
            COIN_REJECT <= 1'b0;
            COIN_READY  <= 1'b1;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_n;
            CREDIT      <= credit_n;
            DIME_CNT    <= dime_n;
            NICKEL_CNT  <= nickel_n;
            CAN_REQ     <= can_req_n;
            DIME_REQ    <= dime_req_n;
            NICKEL_REQ  <= nickel_req_n;
            COIN_REJECT <= reject_n;
            COIN_READY  <= (state_n == S_IDLE);
            BUSY        <= (state_n != S_IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        credit_n = CREDIT;
        dime_n   = DIME_CNT;
        nickel_n = NICKEL_CNT;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    credit_n = CREDIT + coin_value;
                    if (credit_n >= PRICE_C)
                        state_n = S_VEND;
                end else if (CANCEL && CREDIT != '0) begin
                    state_n = change_path(CREDIT, DIME_CNT, NICKEL_CNT);
                end
                if (REFILL) begin
                    dime_n   = INV_W'(DIME_INIT);
                    nickel_n = INV_W'(NICKEL_INIT);
                end
            end
            S_VEND: begin
                if (CAN_REQ && CAN_ACK) begin
                    credit_n = CREDIT - PRICE_C;
                    state_n  = change_path(credit_n, DIME_CNT, NICKEL_CNT);
                end
            end
            S_DIME: begin
                if (DIME_REQ && DIME_ACK) begin
                    credit_n = CREDIT - DIME_V;
                    dime_n   = DIME_CNT - 1'b1;
                    state_n  = change_path(credit_n, dime_n, NICKEL_CNT);
                end
            end
            S_NICKEL: begin
                if (NICKEL_REQ && NICKEL_ACK) begin
                    credit_n = CREDIT - NICKEL_V;
                    nickel_n = NICKEL_CNT - 1'b1;
                    state_n  = change_path(credit_n, DIME_CNT, nickel_n);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A REQ rises on entry from IDLE, or one cycle after any acknowledge, so every REQ is preceded by a low cycle.
    always_comb begin
        ack_now      = (CAN_REQ && CAN_ACK) || (DIME_REQ && DIME_ACK) || (NICKEL_REQ && NICKEL_ACK);
        can_req_n    = (state_n == S_VEND)   && (state == S_IDLE || (state == S_VEND   && !ack_now));
        dime_req_n   = (state_n == S_DIME)   && (state == S_IDLE || (state == S_DIME   && !ack_now));
        nickel_req_n = (state_n == S_NICKEL) && (state == S_IDLE || (state == S_NICKEL && !ack_now));
        reject_n     = accept && (COIN_CODE == 2'b11);
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed self-checking bench for vend_sequencer
module tb_vend_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       COIN_VALID = 1'b0;
    logic [1:0] COIN_CODE = 2'b00;
    logic       CANCEL = 1'b0, REFILL = 1'b0;
    logic       CAN_ACK = 1'b0, DIME_ACK = 1'b0, NICKEL_ACK = 1'b0;

    logic       COIN_READY, COIN_REJECT, CAN_REQ, DIME_REQ, NICKEL_REQ, BUSY;
    logic [6:0] CREDIT;
    logic [3:0] DIME_CNT, NICKEL_CNT;

    logic       COIN_READY2, COIN_REJECT2, CAN_REQ2, DIME_REQ2, NICKEL_REQ2, BUSY2;
    logic [6:0] CREDIT2;
    logic [3:0] DIME_CNT2, NICKEL_CNT2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    vend_sequencer u_dut (
        .CLK(CLK), .RST(RST), .COIN_VALID(COIN_VALID), .COIN_CODE(COIN_CODE),
        .COIN_READY(COIN_READY), .COIN_REJECT(COIN_REJECT), .CANCEL(CANCEL), .REFILL(REFILL),
        .CAN_REQ(CAN_REQ), .CAN_ACK(CAN_ACK), .DIME_REQ(DIME_REQ), .DIME_ACK(DIME_ACK),
        .NICKEL_REQ(NICKEL_REQ), .NICKEL_ACK(NICKEL_ACK), .CREDIT(CREDIT),
        .DIME_CNT(DIME_CNT), .NICKEL_CNT(NICKEL_CNT), .BUSY(BUSY)
    );

    // Low-inventory variant shares every input with u_dut.
    vend_sequencer #(.DIME_INIT(0), .NICKEL_INIT(1)) u_dut_low (
        .CLK(CLK), .RST(RST), .COIN_VALID(COIN_VALID), .COIN_CODE(COIN_CODE),
        .COIN_READY(COIN_READY2), .COIN_REJECT(COIN_REJECT2), .CANCEL(CANCEL), .REFILL(REFILL),
        .CAN_REQ(CAN_REQ2), .CAN_ACK(CAN_ACK), .DIME_REQ(DIME_REQ2), .DIME_ACK(DIME_ACK),
        .NICKEL_REQ(NICKEL_REQ2), .NICKEL_ACK(NICKEL_ACK), .CREDIT(CREDIT2),
        .DIME_CNT(DIME_CNT2), .NICKEL_CNT(NICKEL_CNT2), .BUSY(BUSY2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic insert(input logic [1:0] code);
        COIN_VALID = 1'b1;
        COIN_CODE  = code;
        tick();
        COIN_VALID = 1'b0;
    endtask

    // which: 0 can, 1 dime, 2 nickel on u_dut; 3..5 the same on u_dut_low
    task automatic handshake(input int which, input string tag);
        logic [5:0] reqs;
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            reqs = {NICKEL_REQ2, DIME_REQ2, CAN_REQ2, NICKEL_REQ, DIME_REQ, CAN_REQ};
            if (reqs[which]) begin
                case (which % 3)
                    0: CAN_ACK = 1'b1;
                    1: DIME_ACK = 1'b1;
                    default: NICKEL_ACK = 1'b1;
                endcase
                tick();
                CAN_ACK = 1'b0; DIME_ACK = 1'b0; NICKEL_ACK = 1'b0;
                seen = 1;
            end else begin
                tick();
            end
        end
        chk(tag, int'(seen), 1);
    endtask

    logic [2:0] exp_reqs [6] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000};

    initial begin
        tick(); tick();
        RST = 1'b0;
        chk("rst_credit", CREDIT, 0);
        chk("rst_ready", COIN_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_reqs", {CAN_REQ, DIME_REQ, NICKEL_REQ, COIN_REJECT}, 0);
        chk("rst_dcnt", DIME_CNT, 8);
        chk("rst_ncnt", NICKEL_CNT, 8);

        // Exact price, coin offered during VEND is not taken
        insert(2'b01); insert(2'b01); insert(2'b01);
        chk("exact_canreq", CAN_REQ, 1);
        chk("exact_credit", CREDIT, 30);
        chk("exact_ready", COIN_READY, 0);
        insert(2'b01);
        chk("vend_coin_ignored", CREDIT, 30);
        tick();
        CAN_ACK = 1'b1; tick(); CAN_ACK = 1'b0;
        chk("exact_canreq_drop", CAN_REQ, 0);
        chk("exact_no_change", {DIME_REQ, NICKEL_REQ}, 0);
        chk("exact_credit0", CREDIT, 0);
        chk("exact_idle", BUSY, 0);

        // 50 cents -> can + two dimes
        insert(2'b10); insert(2'b10);
        chk("q2_canreq", CAN_REQ, 1);
        handshake(0, "q2_can_hs");
        chk("q2_credit20", CREDIT, 20);
        chk("q2_gap", DIME_REQ, 0);
        handshake(1, "q2_dime_hs1");
        chk("q2_credit10", CREDIT, 10);
        handshake(1, "q2_dime_hs2");
        chk("q2_credit0", CREDIT, 0);
        chk("q2_dcnt", DIME_CNT, 6);
        chk("q2_ncnt", NICKEL_CNT, 8);
        chk("q2_idle", BUSY, 0);

        // 35 cents -> can + one nickel
        insert(2'b01); insert(2'b10);
        handshake(0, "dq_can_hs");
        handshake(2, "dq_nickel_hs");
        chk("dq_credit", CREDIT, 0);
        chk("dq_ncnt", NICKEL_CNT, 7);
        chk("dq_dcnt", DIME_CNT, 6);
        chk("dq_idle", BUSY, 0);

        // Cancel 15 -> dime then nickel, no can
        insert(2'b00); insert(2'b01);
        CANCEL = 1'b1; tick(); CANCEL = 1'b0;
        chk("cancel_dimereq", DIME_REQ, 1);
        chk("cancel_nocan", CAN_REQ, 0);
        handshake(1, "cancel_dime_hs");
        chk("cancel_credit5", CREDIT, 5);
        handshake(2, "cancel_nickel_hs");
        chk("cancel_credit0", CREDIT, 0);
        chk("cancel_dcnt", DIME_CNT, 5);
        chk("cancel_ncnt", NICKEL_CNT, 6);
        chk("cancel_idle", BUSY, 0);

        // Invalid code
        insert(2'b11);
        chk("reject_pulse", COIN_REJECT, 1);
        chk("reject_credit", CREDIT, 0);
        tick();
        chk("reject_clear", COIN_REJECT, 0);

        // Coin and cancel together: coin wins
        insert(2'b00);
        COIN_VALID = 1'b1; COIN_CODE = 2'b01; CANCEL = 1'b1;
        tick();
        COIN_VALID = 1'b0; CANCEL = 1'b0;
        chk("coin_cancel_credit", CREDIT, 15);
        chk("coin_cancel_idle", BUSY, 0);
        chk("coin_cancel_noreq", DIME_REQ, 0);
        CANCEL = 1'b1; tick(); CANCEL = 1'b0;
        handshake(1, "refund_dime_hs");
        handshake(2, "refund_nickel_hs");
        chk("refund_credit", CREDIT, 0);

        // Spurious ACK in IDLE
        DIME_ACK = 1'b1; tick(); tick(); DIME_ACK = 1'b0;
        chk("spurious_dcnt", DIME_CNT, 4);
        chk("spurious_busy", BUSY, 0);
        chk("spurious_credit", CREDIT, 0);

        // ACKs held high: 1-cycle REQs with 1-cycle gaps
        CAN_ACK = 1'b1; DIME_ACK = 1'b1; NICKEL_ACK = 1'b1;
        insert(2'b10); insert(2'b10);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ackhigh_reqs_%0d", i), {NICKEL_REQ, DIME_REQ, CAN_REQ}, exp_reqs[i]);
            tick();
        end
        CAN_ACK = 1'b0; DIME_ACK = 1'b0; NICKEL_ACK = 1'b0;
        chk("ackhigh_credit", CREDIT, 0);
        chk("ackhigh_dcnt", DIME_CNT, 2);
        chk("ackhigh_idle", BUSY, 0);

        // Reset in the middle of a can handshake
        insert(2'b01); insert(2'b01); insert(2'b01);
        chk("midrst_canreq", CAN_REQ, 1);
        RST = 1'b1; tick(); RST = 1'b0;
        chk("midrst_canreq0", CAN_REQ, 0);
        chk("midrst_credit", CREDIT, 0);
        chk("midrst_dcnt", DIME_CNT, 8);

        // Inventory exhaustion on the low-inventory instance
        chk("low_dcnt_init", DIME_CNT2, 0);
        chk("low_ncnt_init", NICKEL_CNT2, 1);
        insert(2'b10); insert(2'b10);
        handshake(3, "low_can_hs");
        chk("low_credit20", CREDIT2, 20);
        handshake(5, "low_nickel_hs");
        chk("low_credit15", CREDIT2, 15);
        chk("low_ncnt0", NICKEL_CNT2, 0);
        chk("low_idle", BUSY2, 0);
        chk("low_no_dime", DIME_REQ2, 0);
        REFILL = 1'b1; tick(); REFILL = 1'b0;
        chk("low_refill_dcnt", DIME_CNT2, 0);
        chk("low_refill_ncnt", NICKEL_CNT2, 1);
        chk("low_carry_credit", CREDIT2, 15);
        insert(2'b00);
        chk("low_carry_add", CREDIT2, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
